// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC, response codes and FSM encoding for the
// instruction fetch unit.
package ifu_fetch_pkg;

  localparam int          PC_BUS   = 32;
  localparam int          INST_BUS = 32;
  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one AR/R read at a time and
// hands inst/pc/flags to decode over valid/ready, then waits for next-PC.
// Ports: clock/reset; npc_*; AR (arvalid/arready/araddr);
// R (rvalid/rready/rdata/rresp); inst_* to decode; fetch_cnt_o.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int               XLEN     = PC_BUS,
  parameter logic [XLEN-1:0]  RESET_PC = RST_PC
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                npc_valid_i,
  input  logic [XLEN-1:0]     npc_i,
  output logic                arvalid_o,
  input  logic                arready_i,
  output logic [XLEN-1:0]     araddr_o,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [INST_BUS-1:0] rdata_i,
  input  logic [1:0]          rresp_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [INST_BUS-1:0] inst_o,
  output logic [XLEN-1:0]     pc_o,
  output logic                acc_fault_o,
  output logic                misalign_o,
  output logic [31:0]         fetch_cnt_o
);

  ifu_state_t state;
  ifu_state_t next;

  logic [XLEN-1:0]     pc;
  logic [INST_BUS-1:0] inst;
  logic                fault;
  logic                mis;
  logic [31:0]         cnt;
  logic                unaligned;
  logic                ar_req;
  logic                r_acc;
  logic                out_vld;

  assign unaligned = pc[1:0] != 2'b00;

  always_comb begin
    next    = state;
    ar_req  = 1'b0;
    r_acc   = 1'b0;
    out_vld = 1'b0;
    unique case (state)
      S_REQ: begin
        if (unaligned) begin
          next = S_OUT;
        end else begin
          ar_req = 1'b1;
          if (arready_i) next = S_RESP;
        end
      end
      S_RESP: begin
        r_acc = 1'b1;
        if (rvalid_i) next = S_OUT;
      end
      S_OUT: begin
        out_vld = 1'b1;
        if (inst_ready_i) next = S_WAIT;
      end
      S_WAIT: begin
        if (npc_valid_i) next = S_REQ;
      end
      default: next = S_REQ;
    endcase
  end

  // Handshake outputs are forced low while reset is held so an
  // in-flight response cannot be consumed during the reset cycle.
  assign arvalid_o    = ar_req  & ~reset;
  assign rready_o     = r_acc   & ~reset;
  assign inst_valid_o = out_vld & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      inst  <= '0;
      fault <= 1'b0;
      mis   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= next;
      unique case (state)
        S_REQ: begin
          if (unaligned) begin
            inst <= '0;
            mis  <= 1'b1;
          end
        end
        S_RESP: begin
          if (rvalid_i) begin
            fault <= rresp_i != RESP_OKAY;
            inst  <= (rresp_i != RESP_OKAY) ? '0 : rdata_i;
          end
        end
        S_OUT: begin
          if (inst_ready_i) cnt <= cnt + 32'd1;
        end
        S_WAIT: begin
          if (npc_valid_i) begin
            pc    <= npc_i;
            fault <= 1'b0;
            mis   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign araddr_o    = pc;
  assign pc_o        = pc;
  assign inst_o      = inst;
  assign acc_fault_o = fault;
  assign misalign_o  = mis;
  assign fetch_cnt_o = cnt;

endmodule
